// File: rtl/cpu_pkg.sv
// Shared CPU definitions: the NOP bubble word and the fetch FSM state encoding.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry fetch output buffer feeding IF/ID; presents a NOP/zero bubble when empty.
module fetch_out_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        consume,
  input  logic        clear,
  output logic        buf_valid,
  output logic [31:0] out_addr,
  output logic [31:0] out_data
);

  logic        valid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= load_addr;
      data_q <= load_data;
    end
  end

  assign buf_valid = valid_q;
  assign out_addr  = valid_q ? addr_q : 32'h0000_0000;
  assign out_data  = valid_q ? data_q : NOP_INSTR;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a time,
// and hands {addr, instr} to IF/ID under the flush > stall > normal protocol.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        checkpre_flush,
  input  logic [31:0] checkpre_target,
  input  logic        feedforward_stall,
  output logic        instrmem_req,
  output logic [31:0] instrmem_addr,
  input  logic        instrmem_gnt,
  input  logic        instrmem_rvalid,
  input  logic [31:0] instrmem_rdata,
  output logic [31:0] instr_addr_o,
  output logic [31:0] instr_data_o,
  output logic        instr_valid_o
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         buf_valid;
  logic         consume;
  logic         load;
  logic         issue;

  assign consume = buf_valid & ~feedforward_stall & ~checkpre_flush;
  // Only request when the single buffer slot is guaranteed free by response time.
  assign issue   = (state_q == FETCH_REQ) & (~buf_valid | consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    load    = 1'b0;
    case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (issue && instrmem_gnt) begin
          state_d = FETCH_WAIT;
          if (checkpre_flush) drop_d = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (instrmem_rvalid) begin
          state_d = FETCH_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!checkpre_flush) begin
            load = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end else if (checkpre_flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (checkpre_flush) pc_d = checkpre_target & ~32'h0000_0003;
  end

  assign instrmem_req  = issue;
  assign instrmem_addr = pc_q;

  fetch_out_buf u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (pc_q),
    .load_data (instrmem_rdata),
    .consume   (consume),
    .clear     (checkpre_flush),
    .buf_valid (buf_valid),
    .out_addr  (instr_addr_o),
    .out_data  (instr_data_o)
  );

  assign instr_valid_o = buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a timed memory model answers fetches, expected
// PCs are queued per scenario and retired whenever IF/ID would take an instruction.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        checkpre_flush;
  logic [31:0] checkpre_target;
  logic        feedforward_stall;
  logic        instrmem_req;
  logic [31:0] instrmem_addr;
  logic        instrmem_gnt;
  logic        instrmem_rvalid;
  logic [31:0] instrmem_rdata;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_data_o;
  logic        instr_valid_o;

  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, iaddr2, idata2;

  int n_checks = 0;
  int n_errors = 0;
  int gnt_delay = 0;
  int rv_delay  = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .checkpre_flush(checkpre_flush), .checkpre_target(checkpre_target),
    .feedforward_stall(feedforward_stall),
    .instrmem_req(instrmem_req), .instrmem_addr(instrmem_addr),
    .instrmem_gnt(instrmem_gnt), .instrmem_rvalid(instrmem_rvalid),
    .instrmem_rdata(instrmem_rdata),
    .instr_addr_o(instr_addr_o), .instr_data_o(instr_data_o),
    .instr_valid_o(instr_valid_o)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .checkpre_flush(1'b0), .checkpre_target(32'h0000_0000),
    .feedforward_stall(1'b0),
    .instrmem_req(req2), .instrmem_addr(addr2),
    .instrmem_gnt(1'b1), .instrmem_rvalid(rvalid2),
    .instrmem_rdata(rdata2),
    .instr_addr_o(iaddr2), .instr_data_o(idata2),
    .instr_valid_o(valid2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_drain(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (i == limit) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_valid(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (instr_valid_o) break;
      @(negedge clk);
    end
    if (i == limit) check("valid_timeout", {31'b0, instr_valid_o}, 32'd1);
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    check({tag, "_data"}, instr_data_o, 32'h0000_0013);
    check({tag, "_addr"}, instr_addr_o, 32'h0000_0000);
  endtask

  // Memory model for the main DUT: programmable grant wait and response delay.
  initial begin
    bit          resp_pend = 0;
    int          resp_cnt  = 0;
    logic [31:0] resp_addr = '0;
    int          wait_cnt  = 0;
    bit          prev_req  = 0;
    bit          prev_flush = 0;
    logic [31:0] prev_addr = '0;
    instrmem_gnt = 1'b0; instrmem_rvalid = 1'b0; instrmem_rdata = '0;
    forever begin
      @(negedge clk); #2;
      instrmem_gnt = 1'b0;
      instrmem_rvalid = 1'b0;
      if (!rst_n) begin
        resp_pend = 0; wait_cnt = 0; prev_req = 0;
      end else begin
        if (resp_pend) begin
          if (resp_cnt == 0) begin
            instrmem_rvalid = 1'b1;
            instrmem_rdata  = mem_word(resp_addr);
            resp_pend = 0;
          end else begin
            resp_cnt--;
          end
        end
        if (prev_req && !prev_flush && instrmem_req)
          check("addr_stable", instrmem_addr, prev_addr);
        if (instrmem_req) begin
          if (wait_cnt >= gnt_delay) begin
            check("addr_align", {30'b0, instrmem_addr[1:0]}, 32'd0);
            instrmem_gnt = 1'b1;
            resp_pend = 1; resp_cnt = rv_delay; resp_addr = instrmem_addr;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
        prev_req   = instrmem_req && !instrmem_gnt;
        prev_flush = checkpre_flush;
        prev_addr  = instrmem_addr;
      end
    end
  end

  // Scoreboard: an instruction retires on every cycle IF/ID would accept it.
  initial begin
    logic [31:0] exp_a;
    forever begin
      @(negedge clk); #3;
      if (rst_n && instr_valid_o && !feedforward_stall && !checkpre_flush) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_a = sb.pop_front();
          check("out_addr", instr_addr_o, exp_a);
          check("out_data", instr_data_o, mem_word(exp_a));
        end
      end
    end
  end

  // Zero-wait memory and capture for the wrap-around instance.
  logic [31:0] cap_a[2];
  logic [31:0] cap_d[2];
  int          n_cap = 0;
  initial begin
    bit          pend2 = 0;
    logic [31:0] paddr2 = '0;
    rvalid2 = 1'b0; rdata2 = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        pend2 = 0; rvalid2 = 1'b0;
      end else begin
        rvalid2 = pend2;
        rdata2  = mem_word(paddr2);
        pend2   = req2;
        paddr2  = addr2;
      end
      #1;
      if (rst_n && valid2 && n_cap < 2) begin
        cap_a[n_cap] = iaddr2;
        cap_d[n_cap] = idata2;
        n_cap++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [6:0] vpat;
    rst_n = 1'b0; feedforward_stall = 1'b0; checkpre_flush = 1'b0; checkpre_target = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, instrmem_req}, 32'd0);
    check("rst_imem_addr", instrmem_addr, 32'h0000_0000);
    check_bubble("rst");
    check("rst_wrap_addr", addr2, 32'hFFFF_FFFC);

    // Back-to-back fetch: 0,4,8 with valid high every other cycle.
    sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vpat[i] = instr_valid_o;
    end
    check("valid_pattern", {25'b0, vpat}, 32'b1010100);

    // Stall with a full buffer: output frozen, no request.
    @(negedge clk);
    feedforward_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, instr_valid_o}, 32'd1);
      check("stall_addr", instr_addr_o, 32'h0000_000C);
      check("stall_data", instr_data_o, mem_word(32'h0000_000C));
      check("stall_req", {31'b0, instrmem_req}, 32'd0);
    end
    @(negedge clk);
    sb.push_back(32'hC); sb.push_back(32'h10);
    rv_delay = 3;
    feedforward_stall = 1'b0;
    wait_drain(40);

    // Flush while in WAIT: in-flight fetch of 0x14 must never appear.
    checkpre_flush = 1'b1; checkpre_target = 32'h0000_0100;
    @(negedge clk);
    checkpre_flush = 1'b0; feedforward_stall = 1'b1; rv_delay = 0;
    check_bubble("flush_gap1");
    @(negedge clk);
    check_bubble("flush_gap2");
    wait_valid(30);
    check("redirect_addr", instr_addr_o, 32'h0000_0100);
    check("redirect_data", instr_data_o, mem_word(32'h0000_0100));

    // Flush and stall together: flush clears the held buffer.
    @(negedge clk);
    checkpre_flush = 1'b1; checkpre_target = 32'h0000_0100;
    @(negedge clk);
    checkpre_flush = 1'b0;
    check_bubble("flush_stall");
    check("flush_stall_pc", instrmem_addr, 32'h0000_0100);
    check("flush_stall_req", {31'b0, instrmem_req}, 32'd1);
    gnt_delay = 3;
    feedforward_stall = 1'b0;
    sb.push_back(32'h100);
    wait_drain(40);

    // Grant delayed: withdraw pending 0x104 request, reissue at aligned 0x103.
    check("gnt_wait_req", {31'b0, instrmem_req}, 32'd1);
    check("gnt_wait_addr", instrmem_addr, 32'h0000_0104);
    checkpre_flush = 1'b1; checkpre_target = 32'h0000_0103;
    @(negedge clk);
    checkpre_flush = 1'b0;
    check("reissue_req", {31'b0, instrmem_req}, 32'd1);
    check("reissue_addr", instrmem_addr, 32'h0000_0100);
    sb.push_back(32'h100);
    wait_drain(40);
    feedforward_stall = 1'b1;
    gnt_delay = 0;

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("wrap_count", 32'(n_cap), 32'd2);
    check("wrap_addr0", cap_a[0], 32'hFFFF_FFFC);
    check("wrap_data0", cap_d[0], mem_word(32'hFFFF_FFFC));
    check("wrap_addr1", cap_a[1], 32'h0000_0000);
    check("wrap_data1", cap_d[1], mem_word(32'h0000_0000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
